// File: rtl/sata_rx_dword_aligner_if.sv
// Bus between the transceiver RX path, the dword aligner and the link layer.
// The master drives the raw decoded words; the slave (aligner) returns aligned dwords and lock status.
interface sata_rx_dword_aligner_if;
  logic [31:0] rx_data;
  logic [3:0]  rx_datak;
  logic [3:0]  rx_errdetect;
  logic [3:0]  rx_disperr;
  logic [31:0] o_data;
  logic [3:0]  o_datak;
  logic        o_err;
  logic        o_align;
  logic        o_valid;
  logic        locked;
  logic [1:0]  offset;
  logic        wa_patternalign;

  modport master (
    output rx_data, rx_datak, rx_errdetect, rx_disperr,
    input  o_data, o_datak, o_err, o_align, o_valid, locked, offset, wa_patternalign
  );

  modport slave (
    input  rx_data, rx_datak, rx_errdetect, rx_disperr,
    output o_data, o_datak, o_err, o_align, o_valid, locked, offset, wa_patternalign
  );
endinterface

// File: rtl/sata_rx_dword_aligner.sv
// SATA RX dword aligner: finds ALIGN (K28.5 D10.2 D10.2 D27.3), rotates the byte
// stream so K28.5 sits in lane 0, and qualifies output with a HUNT/CHECK/LOCKED FSM.
module sata_rx_dword_aligner #(
  parameter int LOCK_ALIGNS = 2,
  parameter int ERR_LIMIT   = 4,
  parameter int DROP_ALIGN  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  sata_rx_dword_aligner_if.slave bus
);
  localparam logic [31:0] ALIGN_PRIM = 32'h7B4A4ABC;
  localparam logic [3:0]  LA = 4'(LOCK_ALIGNS);
  localparam logic [7:0]  EL = 8'(ERR_LIMIT);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  e;
  } rxw_t;

  rxw_t   a_q, b_q;
  state_t state_q, state_d;
  logic [1:0] offset_q, offset_d;
  logic [3:0] align_cnt_q, align_cnt_d, align_inc;
  logic [7:0] err_cnt_q, err_cnt_d, err_inc;

  logic [31:0] data_q;
  logic [3:0]  datak_q;
  logic        err_q, align_q, valid_q, locked_q, wa_q;
  logic [1:0]  offs_q;

  // Only 7 window bytes are ever reachable: offset 3 ends at byte 6.
  logic [55:0] win_d;
  logic [6:0]  win_k, win_e;
  logic [3:0][31:0] cand_d;
  logic [3:0][3:0]  cand_k;
  logic [3:0]       cand_err, match;
  logic [3:0]       other;
  logic             sel_match, sel_err;

  assign win_d = {a_q.d[23:0], b_q.d};
  assign win_k = {a_q.k[2:0], b_q.k};
  assign win_e = {a_q.e[2:0], b_q.e};

  for (genvar g = 0; g < 4; g++) begin : g_cand
    assign cand_d[g]   = win_d[8*g +: 32];
    assign cand_k[g]   = win_k[g +: 4];
    assign cand_err[g] = |win_e[g +: 4];
    assign match[g]    = (cand_d[g] == ALIGN_PRIM) && (cand_k[g] == 4'b0001) && !cand_err[g];
  end

  assign sel_match = match[offset_q];
  assign sel_err   = cand_err[offset_q];
  assign other     = match & ~(4'b0001 << offset_q);

  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= '{d: bus.rx_data, k: bus.rx_datak, e: bus.rx_errdetect | bus.rx_disperr};
      b_q <= a_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    align_cnt_d = align_cnt_q;
    err_cnt_d   = err_cnt_q;
    align_inc   = (align_cnt_q == 4'hF) ? align_cnt_q : align_cnt_q + 4'd1;
    err_inc     = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    case (state_q)
      HUNT: begin
        err_cnt_d = 8'd0;
        if (|match) begin
          offset_d    = lowest(match);
          align_cnt_d = 4'd1;
          state_d     = (LA == 4'd1) ? LOCKED : CHECK;
        end
      end
      CHECK: begin
        err_cnt_d = 8'd0;
        if (sel_err) begin
          state_d     = HUNT;
          align_cnt_d = 4'd0;
        end else if (sel_match) begin
          align_cnt_d = align_inc;
          if (align_inc >= LA) state_d = LOCKED;
        end else if (|other) begin
          offset_d    = lowest(other);
          align_cnt_d = 4'd1;
        end
      end
      LOCKED: begin
        err_cnt_d = sel_err ? err_inc : 8'd0;
        // Error run or a competing ALIGN both throw the link back to HUNT.
        if ((sel_err && (err_inc >= EL)) || (!sel_match && (|other))) begin
          state_d     = HUNT;
          err_cnt_d   = 8'd0;
          align_cnt_d = 4'd0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      offset_q    <= 2'd0;
      align_cnt_q <= 4'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      align_cnt_q <= align_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Status is captured with the dword so the link layer sees a coherent view.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      datak_q  <= '0;
      err_q    <= 1'b0;
      align_q  <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      offs_q   <= 2'd0;
      wa_q     <= 1'b0;
    end else begin
      data_q   <= cand_d[offset_q];
      datak_q  <= cand_k[offset_q];
      err_q    <= sel_err;
      align_q  <= sel_match;
      valid_q  <= (state_q == LOCKED) && !((DROP_ALIGN != 0) && sel_match);
      locked_q <= (state_q == LOCKED);
      offs_q   <= offset_q;
      wa_q     <= (state_q == HUNT);
    end
  end

  assign bus.o_data          = data_q;
  assign bus.o_datak         = datak_q;
  assign bus.o_err           = err_q;
  assign bus.o_align         = align_q;
  assign bus.o_valid         = valid_q;
  assign bus.locked          = locked_q;
  assign bus.offset          = offs_q;
  assign bus.wa_patternalign = wa_q;
endmodule

// File: doc/sata_rx_dword_aligner.md
Name: sata_rx_dword_aligner

Overview:
- Sits directly downstream of the Arria 10 SATA transceiver RX path, in the recovered RX clock domain.
- Consumes raw 32-bit 8b/10b-decoded words with per-byte K, code-error and disparity-error flags.
- Finds the ALIGN primitive, rotates the byte stream so the K28.5 always lands in lane 0, and qualifies the result with a lock state machine.
- Delivers dword-aligned data, the ALIGN strobe and error flags to the link layer.

Parameters:
- LOCK_ALIGNS, 2: number of consecutive clean ALIGN primitives at the same offset required to declare lock (1..15).
- ERR_LIMIT, 4: number of consecutive errored output dwords that drops lock (1..255).
- DROP_ALIGN, 1: when 1, ALIGN dwords are not flagged valid on the output.

Ports:
- clk  in  1  RX recovered parallel clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  32  decoded RX word; byte n in bits [8n+7:8n], byte 0 oldest.
- rx_datak  in  4  per-byte K flag.
- rx_errdetect  in  4  per-byte 10b code error.
- rx_disperr  in  4  per-byte disparity error.
- o_data  out  32  aligned dword.
- o_datak  out  4  aligned K flags.
- o_err  out  1  any errdetect|disperr in the 4 bytes forming o_data.
- o_align  out  1  o_data/o_datak is an ALIGN primitive.
- o_valid  out  1  dword qualified for link layer.
- locked  out  1  FSM in LOCKED.
- offset  out  2  current byte rotation.
- wa_patternalign  out  1  high while in HUNT (feeds transceiver rx_std_wa_patternalign).

Behaviour:
- Reset values: all outputs 0; FSM = HUNT; offset = 0; all counters 0. wa_patternalign is 0 during reset and goes to 1 on the first clock after reset release.
- Input stage: rx_* are registered every clock into stage A; A is copied to stage B the next clock. No input valid signal; every clock carries a word.
- Window: W = {A, B}, 64 bits; B occupies bytes 0..3, A occupies bytes 4..7.
- Candidate at offset q is W bytes q..q+3 with the matching K/error bits.
- Candidate is ALIGN when:
  - bytes equal 0xBC, 0x4A, 0x4A, 0x7B;
  - K flags = 4'b0001;
  - all 4 error bits are clear.
- Output register: loads the candidate at the current offset each clock.
  - Fixed latency 3 clk from the input word carrying aligned byte 0 to o_data.
  - o_err is the OR of the errdetect and disperr bits of the selected 4 bytes.
  - o_align is the ALIGN match at the selected offset.
- FSM:
  - HUNT: wa_patternalign = 1. Evaluate all four offsets. If any offset q matches ALIGN (lowest q wins on a tie): offset <= q, align_cnt <= 1, go to CHECK. If LOCK_ALIGNS = 1, go directly to LOCKED instead.
  - CHECK:
    - ALIGN at the current offset: align_cnt += 1; when align_cnt reaches LOCK_ALIGNS, go to LOCKED.
    - ALIGN found only at a different offset: offset <= that offset, align_cnt <= 1, stay in CHECK.
    - Any selected dword with o_err: return to HUNT, align_cnt <= 0.
    - Non-ALIGN clean dwords: no change to align_cnt.
  - LOCKED:
    - Each selected dword with an error increments err_cnt; each clean dword clears it.
    - err_cnt reaching ERR_LIMIT: go to HUNT and clear err_cnt.
    - ALIGN detected at another offset while none is detected at the current offset: go to HUNT immediately.
- Offset is held while locked; it only changes in HUNT/CHECK as described above.
- o_valid: 1 only when the FSM state used for that output dword is LOCKED, and not (DROP_ALIGN = 1 and o_align = 1). o_err dwords are still marked valid; the link layer handles them.
- locked and offset are registered alongside the output, so they are coherent with o_data in the same cycle.
- Simultaneous error and ALIGN on one dword: the dword is not an ALIGN because errors disqualify it, so the error path applies.
- Counters saturate and never wrap.
- Reset asserted mid-stream clears everything asynchronously. After release the FSM restarts in HUNT, and the pipeline outputs are 0 until refilled.

Test Plan:
- ALIGN stream at byte offset 2 (K28.5 in input lane 2) → offset = 2; locked rises after the 2nd ALIGN plus 3 clk; o_data of ALIGN = 0x7B4A4ABC, o_datak = 4'b0001; o_valid = 0 on ALIGN dwords, 1 on the data dwords between.
- Stream already at offset 0 with SYNC dwords (0xB5B5957C, K = 0001) → o_data equals the input delayed 3 clk; o_valid = 1 on every non-ALIGN dword after lock.
- Locked, inject disperr in 3 consecutive dwords then 1 clean dword, repeated → lock held with o_err pulsed; then 4 consecutive errored dwords → locked = 0 and wa_patternalign = 1 one clock later.
- Locked at offset 1; stream shifts to offset 3 → HUNT, then relock with offset = 3 after 2 ALIGNs.
- In CHECK after the 1st ALIGN, a codeword error arrives → back to HUNT, align_cnt = 0; lock requires 2 fresh ALIGNs.
- Assert reset_n low while locked → all outputs 0 immediately; after release, relock on a clean ALIGN stream within the expected latency.
